// File: rtl/id_stage_pipe_if.sv
// IF/ID-side, regfile, forwarding and ID/EX-side signals of the decode stage.
interface id_stage_pipe_if #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned NUM_FWD    = 2,
    parameter int unsigned ALUOP_W    = 8,
    parameter int unsigned ALUSEL_W   = 3,
    parameter int unsigned CNT_W      = 16
);
    logic                          flush_i;
    logic                          in_valid_i;
    logic                          in_ready_o;
    logic [DATA_W-1:0]             pc_i;
    logic [31:0]                   inst_i;
    logic                          reg1_re_o;
    logic                          reg2_re_o;
    logic [REG_ADDR_W-1:0]         reg1_addr_o;
    logic [REG_ADDR_W-1:0]         reg2_addr_o;
    logic [DATA_W-1:0]             reg1_data_i;
    logic [DATA_W-1:0]             reg2_data_i;
    logic [NUM_FWD-1:0]            fwd_wreg_i;
    logic [NUM_FWD*REG_ADDR_W-1:0] fwd_wd_i;
    logic [NUM_FWD*DATA_W-1:0]     fwd_wdata_i;
    logic [NUM_FWD-1:0]            fwd_pending_i;
    logic                          out_valid_o;
    logic                          out_ready_i;
    logic [DATA_W-1:0]             pc_o;
    logic [ALUOP_W-1:0]            aluop_o;
    logic [ALUSEL_W-1:0]           alusel_o;
    logic [DATA_W-1:0]             reg1_o;
    logic [DATA_W-1:0]             reg2_o;
    logic [REG_ADDR_W-1:0]         wd_o;
    logic                          wreg_o;
    logic                          instvalid_o;
    logic                          stall_o;
    logic [CNT_W-1:0]              stall_cnt_o;

    // Decode stage side
    modport slave (
        input  flush_i, in_valid_i, pc_i, inst_i, reg1_data_i, reg2_data_i,
               fwd_wreg_i, fwd_wd_i, fwd_wdata_i, fwd_pending_i, out_ready_i,
        output in_ready_o, reg1_re_o, reg2_re_o, reg1_addr_o, reg2_addr_o,
               out_valid_o, pc_o, aluop_o, alusel_o, reg1_o, reg2_o, wd_o,
               wreg_o, instvalid_o, stall_o, stall_cnt_o
    );

    // Surrounding pipeline side
    modport master (
        output flush_i, in_valid_i, pc_i, inst_i, reg1_data_i, reg2_data_i,
               fwd_wreg_i, fwd_wd_i, fwd_wdata_i, fwd_pending_i, out_ready_i,
        input  in_ready_o, reg1_re_o, reg2_re_o, reg1_addr_o, reg2_addr_o,
               out_valid_o, pc_o, aluop_o, alusel_o, reg1_o, reg2_o, wd_o,
               wreg_o, instvalid_o, stall_o, stall_cnt_o
    );
endinterface

// File: rtl/id_stage_pipe.sv
// MIPS instruction decode stage: logic/immediate/shift decode, operand
// forwarding, load-use stall and a valid/ready ID/EX register.
module id_stage_pipe #(
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned NUM_FWD    = 2,
    parameter int unsigned ALUOP_W    = 8,
    parameter int unsigned ALUSEL_W   = 3,
    parameter int unsigned CNT_W      = 16
) (
    input  logic           clk,
    input  logic           rst,
    id_stage_pipe_if.slave bus
);
    localparam logic [5:0] OP_SPECIAL = 6'b000000;
    localparam logic [5:0] OP_ANDI    = 6'b001100;
    localparam logic [5:0] OP_ORI     = 6'b001101;
    localparam logic [5:0] OP_XORI    = 6'b001110;
    localparam logic [5:0] OP_LUI     = 6'b001111;
    localparam logic [5:0] FN_AND     = 6'b100100;
    localparam logic [5:0] FN_OR      = 6'b100101;
    localparam logic [5:0] FN_XOR     = 6'b100110;
    localparam logic [5:0] FN_NOR     = 6'b100111;
    localparam logic [5:0] FN_SLL     = 6'b000000;
    localparam logic [5:0] FN_SRL     = 6'b000010;
    localparam logic [5:0] FN_SRA     = 6'b000011;
    localparam logic [7:0] EXE_NOP_OP = 8'b00000000;
    localparam logic [7:0] EXE_AND_OP = 8'b00100100;
    localparam logic [7:0] EXE_OR_OP  = 8'b00100101;
    localparam logic [7:0] EXE_XOR_OP = 8'b00100110;
    localparam logic [7:0] EXE_NOR_OP = 8'b00100111;
    localparam logic [7:0] EXE_SLL_OP = 8'b01111100;
    localparam logic [7:0] EXE_SRL_OP = 8'b00000010;
    localparam logic [7:0] EXE_SRA_OP = 8'b00000011;
    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

    logic [5:0]            w_op;
    logic [5:0]            w_funct;
    logic [ALUOP_W-1:0]    w_aluop;
    logic [ALUSEL_W-1:0]   w_alusel;
    logic [REG_ADDR_W-1:0] w_wd;
    logic                  w_wreg_raw;
    logic                  w_wreg;
    logic                  w_instvalid;
    logic [1:0]            w_re;
    logic [REG_ADDR_W-1:0] w_addr [2];
    logic [DATA_W-1:0]     w_rf   [2];
    logic [DATA_W-1:0]     w_imm  [2];
    logic [DATA_W-1:0]     w_fdat [2];
    logic [DATA_W-1:0]     w_opnd [2];
    logic [1:0]            w_hit;
    logic [1:0]            w_pend;
    logic [1:0]            w_haz;
    logic                  w_stall;
    logic                  w_in_ready;

    logic                  r_valid;
    logic [DATA_W-1:0]     r_pc;
    logic [ALUOP_W-1:0]    r_aluop;
    logic [ALUSEL_W-1:0]   r_alusel;
    logic [DATA_W-1:0]     r_reg1;
    logic [DATA_W-1:0]     r_reg2;
    logic [REG_ADDR_W-1:0] r_wd;
    logic                  r_wreg;
    logic                  r_instvalid;
    logic [CNT_W-1:0]      r_stall_cnt;

    assign w_op      = bus.inst_i[31:26];
    assign w_funct   = bus.inst_i[5:0];
    assign w_addr[0] = REG_ADDR_W'(bus.inst_i[25:21]);
    assign w_addr[1] = REG_ADDR_W'(bus.inst_i[20:16]);
    assign w_rf[0]   = bus.reg1_data_i;
    assign w_rf[1]   = bus.reg2_data_i;

    // Instruction decode: ALU controls, read enables, immediates, destination
    always_comb begin
        w_aluop     = ALUOP_W'(EXE_NOP_OP);
        w_alusel    = ALUSEL_W'(EXE_RES_NOP);
        w_wd        = '0;
        w_wreg_raw  = 1'b0;
        w_instvalid = 1'b0;
        w_re        = 2'b00;
        w_imm[0]    = '0;
        w_imm[1]    = '0;
        unique case (w_op)
            OP_SPECIAL: begin
                unique case (w_funct)
                    FN_AND, FN_OR, FN_XOR, FN_NOR: begin
                        w_instvalid = 1'b1;
                        w_wreg_raw  = 1'b1;
                        w_wd        = REG_ADDR_W'(bus.inst_i[15:11]);
                        w_re        = 2'b11;
                        w_alusel    = ALUSEL_W'(EXE_RES_LOGIC);
                        w_aluop     = (w_funct == FN_AND) ? ALUOP_W'(EXE_AND_OP) :
                                      (w_funct == FN_OR)  ? ALUOP_W'(EXE_OR_OP)  :
                                      (w_funct == FN_XOR) ? ALUOP_W'(EXE_XOR_OP) :
                                                            ALUOP_W'(EXE_NOR_OP);
                    end
                    FN_SLL, FN_SRL, FN_SRA: begin
                        w_instvalid = 1'b1;
                        w_wreg_raw  = 1'b1;
                        w_wd        = REG_ADDR_W'(bus.inst_i[15:11]);
                        w_re        = 2'b10;
                        w_imm[0]    = DATA_W'(bus.inst_i[10:6]);
                        w_alusel    = ALUSEL_W'(EXE_RES_SHIFT);
                        w_aluop     = (w_funct == FN_SLL) ? ALUOP_W'(EXE_SLL_OP) :
                                      (w_funct == FN_SRL) ? ALUOP_W'(EXE_SRL_OP) :
                                                            ALUOP_W'(EXE_SRA_OP);
                    end
                    default: ;
                endcase
            end
            OP_ANDI, OP_ORI, OP_XORI: begin
                w_instvalid = 1'b1;
                w_wreg_raw  = 1'b1;
                w_wd        = REG_ADDR_W'(bus.inst_i[20:16]);
                w_re        = 2'b01;
                w_imm[1]    = DATA_W'(bus.inst_i[15:0]);
                w_alusel    = ALUSEL_W'(EXE_RES_LOGIC);
                w_aluop     = (w_op == OP_ANDI) ? ALUOP_W'(EXE_AND_OP) :
                              (w_op == OP_ORI)  ? ALUOP_W'(EXE_OR_OP)  :
                                                  ALUOP_W'(EXE_XOR_OP);
            end
            OP_LUI: begin
                w_instvalid = 1'b1;
                w_wreg_raw  = 1'b1;
                w_wd        = REG_ADDR_W'(bus.inst_i[20:16]);
                w_imm[1]    = DATA_W'({bus.inst_i[15:0], 16'h0000});
                w_alusel    = ALUSEL_W'(EXE_RES_LOGIC);
                w_aluop     = ALUOP_W'(EXE_OR_OP);
            end
            default: ;
        endcase
        w_wreg = w_wreg_raw && (w_wd != '0);
    end

    // Operand select per read port; the youngest matching source overrides older ones
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_hit[p]  = 1'b0;
            w_pend[p] = 1'b0;
            w_fdat[p] = '0;
            for (int k = int'(NUM_FWD) - 1; k >= 0; k--) begin
                if (bus.fwd_wreg_i[k] &&
                    (bus.fwd_wd_i[k*REG_ADDR_W +: REG_ADDR_W] == w_addr[p])) begin
                    w_hit[p]  = 1'b1;
                    w_pend[p] = bus.fwd_pending_i[k];
                    w_fdat[p] = bus.fwd_wdata_i[k*DATA_W +: DATA_W];
                end
            end
            if (!w_re[p])                w_opnd[p] = w_imm[p];
            else if (w_addr[p] == '0)    w_opnd[p] = '0;
            else if (w_hit[p])           w_opnd[p] = w_fdat[p];
            else                         w_opnd[p] = w_rf[p];
            w_haz[p] = w_re[p] && (w_addr[p] != '0) && w_hit[p] && w_pend[p];
        end
    end

    assign w_stall    = bus.in_valid_i && (|w_haz);
    assign w_in_ready = !w_stall && (!r_valid || bus.out_ready_i);

    // ID/EX register with flush priority and same-cycle drain/refill
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid     <= 1'b0;
            r_pc        <= '0;
            r_aluop     <= ALUOP_W'(EXE_NOP_OP);
            r_alusel    <= ALUSEL_W'(EXE_RES_NOP);
            r_reg1      <= '0;
            r_reg2      <= '0;
            r_wd        <= '0;
            r_wreg      <= 1'b0;
            r_instvalid <= 1'b0;
        end else if (bus.flush_i) begin
            r_valid <= 1'b0;
        end else if (bus.in_valid_i && w_in_ready) begin
            r_valid     <= 1'b1;
            r_pc        <= bus.pc_i;
            r_aluop     <= w_aluop;
            r_alusel    <= w_alusel;
            r_reg1      <= w_opnd[0];
            r_reg2      <= w_opnd[1];
            r_wd        <= w_wd;
            r_wreg      <= w_wreg;
            r_instvalid <= w_instvalid;
        end else if (bus.out_ready_i) begin
            r_valid <= 1'b0;
        end
    end

    // Saturating count of stalled cycles
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stall_cnt <= '0;
        end else if (w_stall && !bus.flush_i && (r_stall_cnt != '1)) begin
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end
    end

    assign bus.in_ready_o  = w_in_ready;
    assign bus.stall_o     = w_stall;
    assign bus.reg1_re_o   = w_re[0];
    assign bus.reg2_re_o   = w_re[1];
    assign bus.reg1_addr_o = w_addr[0];
    assign bus.reg2_addr_o = w_addr[1];
    assign bus.out_valid_o = r_valid;
    assign bus.pc_o        = r_pc;
    assign bus.aluop_o     = r_aluop;
    assign bus.alusel_o    = r_alusel;
    assign bus.reg1_o      = r_reg1;
    assign bus.reg2_o      = r_reg2;
    assign bus.wd_o        = r_wd;
    assign bus.wreg_o      = r_wreg;
    assign bus.instvalid_o = r_instvalid;
    assign bus.stall_cnt_o = r_stall_cnt;
endmodule

// File: tb/tb_id_stage_pipe.sv
// Bench for id_stage_pipe: directed scenarios plus random traffic against an
// instruction-level reference model.
module tb_id_stage_pipe;
    localparam int unsigned DW = 32;
    localparam int unsigned RA = 5;
    localparam int unsigned NF = 2;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    id_stage_pipe_if #(.DATA_W(DW), .REG_ADDR_W(RA), .NUM_FWD(NF),
                       .ALUOP_W(8), .ALUSEL_W(3), .CNT_W(16)) bus ();

    id_stage_pipe #(.DATA_W(DW), .REG_ADDR_W(RA), .NUM_FWD(NF),
                    .ALUOP_W(8), .ALUSEL_W(3), .CNT_W(16))
        dut (.clk(clk), .rst(rst), .bus(bus.slave));

    typedef struct {
        logic        iv;
        logic [7:0]  aluop;
        logic [2:0]  alusel;
        logic [4:0]  wd;
        logic        wreg;
        logic [31:0] r1;
        logic [31:0] r2;
        logic        u1;
        logic        u2;
    } dec_t;

    // Expected ID/EX register contents
    logic        m_valid;
    logic [31:0] m_pc;
    logic [7:0]  m_aluop;
    logic [2:0]  m_alusel;
    logic [31:0] m_r1;
    logic [31:0] m_r2;
    logic [4:0]  m_wd;
    logic        m_wreg;
    logic        m_iv;
    logic [15:0] m_cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Youngest in-flight writer of architectural register a, -1 if none
    function automatic int youngest(input logic [4:0] a);
        for (int i = 0; i < int'(NF); i++)
            if (bus.fwd_wreg_i[i] && bus.fwd_wd_i[i*RA +: RA] == a) return i;
        return -1;
    endfunction

    // Architectural value of register a as seen by an instruction in decode
    function automatic logic [31:0] value(input logic [4:0] a, input logic [31:0] rf);
        int y;
        if (a == 5'd0) return 32'h0;
        y = youngest(a);
        if (y >= 0) return bus.fwd_wdata_i[y*DW +: DW];
        return rf;
    endfunction

    function automatic logic waits_on(input logic used, input logic [4:0] a);
        int y;
        if (!used || a == 5'd0) return 1'b0;
        y = youngest(a);
        return (y >= 0) && bus.fwd_pending_i[y];
    endfunction

    function automatic dec_t decode(input logic [31:0] inst, input logic [31:0] rf1,
                                    input logic [31:0] rf2);
        dec_t d;
        logic [4:0] rs, rt, rd;
        rs = inst[25:21]; rt = inst[20:16]; rd = inst[15:11];
        d = '{iv: 1'b0, aluop: 8'h00, alusel: 3'd0, wd: 5'd0, wreg: 1'b0,
              r1: 32'h0, r2: 32'h0, u1: 1'b0, u2: 1'b0};
        if (inst[31:26] == 6'h00) begin
            case (inst[5:0])
                6'h24, 6'h25, 6'h26, 6'h27: begin
                    d.iv = 1'b1; d.aluop = {2'b00, inst[5:0]}; d.alusel = 3'd1;
                    d.wd = rd; d.wreg = 1'b1; d.u1 = 1'b1; d.u2 = 1'b1;
                    d.r1 = value(rs, rf1); d.r2 = value(rt, rf2);
                end
                6'h00, 6'h02, 6'h03: begin
                    d.iv = 1'b1; d.alusel = 3'd2; d.wd = rd; d.wreg = 1'b1; d.u2 = 1'b1;
                    d.aluop = (inst[5:0] == 6'h00) ? 8'h7C : {2'b00, inst[5:0]};
                    d.r1 = {27'h0, inst[10:6]}; d.r2 = value(rt, rf2);
                end
                default: ;
            endcase
        end else if (inst[31:26] >= 6'h0C && inst[31:26] <= 6'h0E) begin
            d.iv = 1'b1; d.alusel = 3'd1; d.wd = rt; d.wreg = 1'b1; d.u1 = 1'b1;
            d.aluop = 8'h24 + 8'(inst[31:26] - 6'h0C);
            d.r1 = value(rs, rf1); d.r2 = {16'h0, inst[15:0]};
        end else if (inst[31:26] == 6'h0F) begin
            d.iv = 1'b1; d.alusel = 3'd1; d.wd = rt; d.wreg = 1'b1; d.aluop = 8'h25;
            d.r1 = 32'h0; d.r2 = {inst[15:0], 16'h0};
        end
        if (d.wd == 5'd0) d.wreg = 1'b0;
        return d;
    endfunction

    task automatic check_regs(input string tag);
        check({tag, ".valid"},  64'(bus.out_valid_o), 64'(m_valid));
        check({tag, ".pc"},     64'(bus.pc_o),        64'(m_pc));
        check({tag, ".aluop"},  64'(bus.aluop_o),     64'(m_aluop));
        check({tag, ".alusel"}, 64'(bus.alusel_o),    64'(m_alusel));
        check({tag, ".reg1"},   64'(bus.reg1_o),      64'(m_r1));
        check({tag, ".reg2"},   64'(bus.reg2_o),      64'(m_r2));
        check({tag, ".wd"},     64'(bus.wd_o),        64'(m_wd));
        check({tag, ".wreg"},   64'(bus.wreg_o),      64'(m_wreg));
        check({tag, ".iv"},     64'(bus.instvalid_o), 64'(m_iv));
        check({tag, ".cnt"},    64'(bus.stall_cnt_o), 64'(m_cnt));
    endtask

    task automatic model_reset();
        m_valid = 1'b0; m_pc = '0; m_aluop = '0; m_alusel = '0; m_r1 = '0;
        m_r2 = '0; m_wd = '0; m_wreg = 1'b0; m_iv = 1'b0; m_cnt = '0;
    endtask

    // One clock: inputs set at the falling edge, checked before and after the rising edge
    task automatic cycle(input string tag);
        dec_t d;
        logic stall, rdy;
        #1;
        d = decode(bus.inst_i, bus.reg1_data_i, bus.reg2_data_i);
        stall = bus.in_valid_i && (waits_on(d.u1, bus.inst_i[25:21]) ||
                                   waits_on(d.u2, bus.inst_i[20:16]));
        rdy = !stall && (!m_valid || bus.out_ready_i);
        check({tag, ".stall"},    64'(bus.stall_o),     64'(stall));
        check({tag, ".in_ready"}, 64'(bus.in_ready_o),  64'(rdy));
        check({tag, ".re"},       64'({bus.reg1_re_o, bus.reg2_re_o}), 64'({d.u1, d.u2}));
        check({tag, ".addr"},     64'({bus.reg1_addr_o, bus.reg2_addr_o}),
                                  64'(bus.inst_i[25:16]));
        if (bus.flush_i) begin
            m_valid = 1'b0;
        end else if (bus.in_valid_i && rdy) begin
            m_valid = 1'b1; m_pc = bus.pc_i; m_aluop = d.aluop; m_alusel = d.alusel;
            m_r1 = d.r1; m_r2 = d.r2; m_wd = d.wd; m_wreg = d.wreg; m_iv = d.iv;
        end else if (bus.out_ready_i) begin
            m_valid = 1'b0;
        end
        if (stall && !bus.flush_i && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
        @(posedge clk);
        @(negedge clk);
        check_regs(tag);
    endtask

    task automatic set_in(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                          input logic ordy, input logic fl);
        bus.in_valid_i = v; bus.pc_i = pc; bus.inst_i = inst;
        bus.out_ready_i = ordy; bus.flush_i = fl;
    endtask

    task automatic no_fwd();
        bus.fwd_wreg_i = '0; bus.fwd_wd_i = '0; bus.fwd_wdata_i = '0; bus.fwd_pending_i = '0;
    endtask

    function automatic logic [31:0] rand_inst();
        logic [4:0] rs, rt, rd, sh;
        logic [15:0] imm;
        int k;
        rs = 5'($urandom_range(0, 3)); rt = 5'($urandom_range(0, 3));
        rd = 5'($urandom_range(0, 3)); sh = 5'($urandom);
        imm = 16'($urandom);
        k = $urandom_range(0, 12);
        case (k)
            0, 1, 2, 3: return {6'h00, rs, rt, rd, sh, 6'(6'h24 + 6'(k))};
            4:          return {6'h00, rs, rt, rd, sh, 6'h00};
            5:          return {6'h00, rs, rt, rd, sh, 6'h02};
            6:          return {6'h00, rs, rt, rd, sh, 6'h03};
            7, 8, 9, 10: return {6'(6'h0C + 6'(k - 7)), rs, rt, imm};
            11:         return {6'h23, rs, rt, imm};
            default:    return {6'h00, rs, rt, rd, sh, 6'h21};
        endcase
    endfunction

    initial begin
        logic [15:0] cnt_before;
        rst = 1'b0;
        no_fwd();
        set_in(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        bus.reg1_data_i = '0; bus.reg2_data_i = '0;
        model_reset();
        repeat (2) @(negedge clk);
        check_regs("reset");
        rst = 1'b1;

        // ORI $3,$1,0x00F0
        set_in(1'b1, 32'h0000_0004, {6'h0D, 5'd1, 5'd3, 16'h00F0}, 1'b1, 1'b0);
        bus.reg1_data_i = 32'h1234_0000;
        cycle("ori");
        check("ori.r1_const", 64'(bus.reg1_o), 64'h1234_0000);
        check("ori.r2_const", 64'(bus.reg2_o), 64'h0000_00F0);
        check("ori.wd_const", 64'(bus.wd_o), 64'd3);

        // OR $4,$1,$2: EX and MEM both write $1, EX wins; $2 from regfile
        set_in(1'b1, 32'h0000_0008, {6'h00, 5'd1, 5'd2, 5'd4, 5'd0, 6'h25}, 1'b1, 1'b0);
        bus.fwd_wreg_i = 2'b11; bus.fwd_wd_i = {5'd1, 5'd1};
        bus.fwd_wdata_i = {32'h0000_5555, 32'h0000_AAAA};
        bus.reg2_data_i = 32'h0000_000F;
        cycle("or_fwd");
        check("or_fwd.r1_const", 64'(bus.reg1_o), 64'h0000_AAAA);
        check("or_fwd.r2_const", 64'(bus.reg2_o), 64'h0000_000F);

        // Load-use: ANDI $5,$2,1 waits on a pending EX result
        cnt_before = bus.stall_cnt_o;
        set_in(1'b1, 32'h0000_000C, {6'h0C, 5'd2, 5'd5, 16'h0001}, 1'b1, 1'b0);
        no_fwd();
        bus.fwd_wreg_i = 2'b01; bus.fwd_wd_i = {5'd0, 5'd2}; bus.fwd_pending_i = 2'b01;
        cycle("ldu_stall");
        check("ldu.bubble", 64'(bus.out_valid_o), 64'd0);
        check("ldu.cnt_const", 64'(bus.stall_cnt_o), 64'(cnt_before + 16'd1));
        bus.fwd_pending_i = 2'b00; bus.fwd_wdata_i = {32'h0, 32'h0000_0007};
        cycle("ldu_issue");
        check("ldu.issue_r1", 64'(bus.reg1_o), 64'h7);

        // Pending on a non-winning older source is ignored
        bus.fwd_wreg_i = 2'b11; bus.fwd_wd_i = {5'd2, 5'd2}; bus.fwd_pending_i = 2'b10;
        cycle("old_pend");

        // Backpressure for three cycles, then back-to-back transfers
        no_fwd();
        set_in(1'b1, 32'h0000_0010, {6'h0D, 5'd1, 5'd3, 16'h0011}, 1'b1, 1'b0);
        cycle("bp_fill");
        set_in(1'b1, 32'h0000_0020, {6'h0E, 5'd2, 5'd6, 16'h0022}, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle("bp_hold");
            check("bp_hold.pc_const", 64'(bus.pc_o), 64'h10);
        end
        bus.out_ready_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.pc_i = 32'h20 + 32'(4 * i);
            cycle("bp_drain");
            check("bp_drain.pc_const", 64'(bus.pc_o), 64'(32'h20 + 32'(4 * i)));
        end

        // Flush beats a valid input with a stalled consumer
        set_in(1'b1, 32'h0000_0030, {6'h0D, 5'd1, 5'd7, 16'h0033}, 1'b0, 1'b1);
        cycle("flush");
        check("flush.valid_const", 64'(bus.out_valid_o), 64'd0);
        check("flush.pc_const", 64'(bus.pc_o), 64'h28);

        // Reserved opcode
        set_in(1'b1, 32'h0000_0040, 32'hFC00_0000, 1'b1, 1'b0);
        cycle("invalid");
        check("invalid.iv_const", 64'(bus.instvalid_o), 64'd0);
        check("invalid.wreg_const", 64'(bus.wreg_o), 64'd0);

        // Random traffic
        for (int n = 0; n < 600; n++) begin
            set_in(($urandom_range(0, 3) != 0), $urandom, rand_inst(),
                   ($urandom_range(0, 3) != 0), ($urandom_range(0, 19) == 0));
            bus.reg1_data_i = $urandom; bus.reg2_data_i = $urandom;
            for (int i = 0; i < int'(NF); i++) begin
                bus.fwd_wreg_i[i] = 1'($urandom);
                bus.fwd_wd_i[i*RA +: RA] = 5'($urandom_range(0, 3));
                bus.fwd_wdata_i[i*DW +: DW] = $urandom;
                bus.fwd_pending_i[i] = ($urandom_range(0, 3) == 0);
            end
            cycle("rand");
        end

        // Asynchronous reset while the output register holds a valid instruction
        no_fwd();
        set_in(1'b1, 32'h0000_0050, {6'h0D, 5'd1, 5'd3, 16'h0055}, 1'b0, 1'b0);
        cycle("pre_rst");
        check("pre_rst.valid", 64'(bus.out_valid_o), 64'd1);
        #2;
        rst = 1'b0;
        #1;
        model_reset();
        check_regs("async_rst");
        @(negedge clk);
        rst = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
